// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sequencing NUM_CORES cores onto one single-port RAM
// Optional build macro ARB_LOCK_EN adds a per-core lock input for back-to-back ownership.
module mem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int AW        = 16,
  parameter int DW        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CORES-1:0]    req,
  input  logic [NUM_CORES-1:0]    we,
  input  logic [NUM_CORES*AW-1:0] addr,
  input  logic [NUM_CORES*DW-1:0] wdata,
`ifdef ARB_LOCK_EN
  input  logic [NUM_CORES-1:0]    lock,
`endif
  output logic [NUM_CORES-1:0]    ack,
  output logic [DW-1:0]           rdata,
  output logic [NUM_CORES-1:0]    grant,
  output logic                    busy,
  output logic [AW-1:0]           mem_addr,
  output logic [DW-1:0]           mem_wdata,
  output logic                    mem_wr,
  output logic                    mem_rd,
  input  logic [DW-1:0]           mem_rdata
);

  localparam int PW = $clog2(NUM_CORES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic [NUM_CORES-1:0]  grant_q, grant_d;
  logic [NUM_CORES-1:0]  ack_q, ack_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic                  lock_q, lock_d;
  logic                  lock_hold;
  logic [PW-1:0]         win;

  // First requester strictly after p, wrapping; scanning downward lets the nearest one win.
  function automatic logic [PW-1:0] rr_pick(input logic [NUM_CORES-1:0] r, input logic [PW-1:0] p);
    logic [PW-1:0] w;
    int            c;
    w = p;
    for (int k = NUM_CORES; k >= 1; k--) begin
      c = (int'(p) + k) % NUM_CORES;
      if (r[c]) w = PW'(c);
    end
    return w;
  endfunction

`ifdef ARB_LOCK_EN
  assign lock_hold = lock_q & req[rr_ptr_q] & lock[rr_ptr_q];
`else
  assign lock_hold = 1'b0;
`endif

  assign win = lock_hold ? rr_ptr_q : rr_pick(req, rr_ptr_q);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    grant_d  = grant_q;
    ack_d    = ack_q;
    rdata_d  = rdata_q;
    lock_d   = lock_q;
    case (state_q)
      IDLE: begin
        lock_d = lock_hold;
        if (|req) begin
          state_d       = ACCESS;
          addr_d        = addr[int'(win)*AW +: AW];
          wdata_d       = wdata[int'(win)*DW +: DW];
          wr_d          = we[win];
          rd_d          = ~we[win];
          grant_d       = '0;
          grant_d[win]  = 1'b1;
          rr_ptr_d      = win;
        end
      end
      ACCESS: begin
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        ack_d   = grant_q;
        if (rd_q) rdata_d = mem_rdata;
        state_d = DONE;
      end
      DONE: begin
`ifdef ARB_LOCK_EN
        lock_d  = |(grant_q & lock);
`endif
        ack_d   = '0;
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= PW'(NUM_CORES - 1);
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      grant_q  <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      lock_q   <= lock_d;
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wr    = wr_q;
  assign mem_rd    = rd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

  localparam int N = 4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  we;
  logic [N*16-1:0] addr;
  logic [N*16-1:0] wdata;
  logic [N-1:0]  ack;
  logic [15:0]   rdata;
  logic [N-1:0]  grant;
  logic          busy;
  logic [15:0]   mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_wr;
  logic          mem_rd;
  logic [15:0]   mem_rdata;
`ifdef ARB_LOCK_EN
  logic [N-1:0]  lock;
`endif

  mem_arbiter #(.NUM_CORES(N), .AW(16), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .ack(ack), .rdata(rdata), .grant(grant), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in RAM: combinational read, write committed at the rising edge.
  logic [15:0] ram [256];
  always @(posedge clk) if (mem_wr) ram[mem_addr[7:0]] <= mem_wdata;
  assign mem_rdata = ram[mem_addr[7:0]];

  typedef struct packed {
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic [7:0]  gap;
  } txn_t;

  txn_t        scr [N][$];
  int          order [$];
  int          n_checks;
  int          n_fail;
  int          m_ptr;
  logic [15:0] m_mem [256];
  logic [15:0] last_rdata;
  int          total_grants;
  int          rise_at [N];
  int          last_wait [N];

  function automatic int model_pick(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic add_txn(input int c, input logic w, input logic [15:0] a, input logic [15:0] d, input int gap);
    txn_t t;
    t.w = w; t.a = a; t.d = d; t.gap = 8'(gap);
    scr[c].push_back(t);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = N - 1;
    last_rdata = 16'h0;
  endtask

  // Drives every core from its script and checks each transaction against the model.
  task automatic run_engine(input int budget);
    bit          in_txn, ack_prev, busy_prev, done;
    int          age, exp_core, w, wait_cnt [N];
    logic [N-1:0] req_edge, acked_mask;
    txn_t        t;
    in_txn = 0; ack_prev = 0; age = 0; exp_core = 0; done = 0;
    busy_prev = busy; req_edge = req;
    for (int c = 0; c < N; c++) wait_cnt[c] = (scr[c].size() != 0) ? int'(scr[c][0].gap) : 0;
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      @(negedge clk);
      acked_mask = '0;
      n_checks++;
      if (mem_wr && mem_rd) begin n_fail++; $display("FAIL rd_wr_overlap: mem_wr=%b mem_rd=%b required not both", mem_wr, mem_rd); end
      if (ack_prev) begin
        n_checks++;
        if (ack !== '0) begin n_fail++; $display("FAIL ack_one_cycle: ack=%b required 0000", ack); end
      end
      if (!busy_prev && req_edge != '0) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL idle_start: busy=%b required 1 (req=%b)", busy, req_edge); end
      end
      if (ack != '0) begin
        n_checks++;
        if (!in_txn || age != 1 || ack !== N'(1 << exp_core))
          begin n_fail++; $display("FAIL ack_pulse: ack=%b age=%0d required %b age 1", ack, age, N'(1 << exp_core)); end
        n_checks++;
        if (rdata !== last_rdata) begin n_fail++; $display("FAIL rdata: got %h required %h", rdata, last_rdata); end
        if (in_txn) begin
          req[exp_core] = 1'b0;
          acked_mask[exp_core] = 1'b1;
          void'(scr[exp_core].pop_front());
          wait_cnt[exp_core] = (scr[exp_core].size() != 0) ? int'(scr[exp_core][0].gap) : 0;
        end
        in_txn = 0;
      end else if (grant != '0 && !in_txn) begin
        w = model_pick(req_edge);
        n_checks++;
        if (w < 0 || grant !== N'(1 << w)) begin
          n_fail++; $display("FAIL grant: got %b required core %0d (req=%b)", grant, w, req_edge);
        end
        if (w >= 0) begin
          t = scr[w][0];
          n_checks++;
          if (mem_wr !== t.w || mem_rd !== ~t.w || mem_addr !== t.a || (t.w && mem_wdata !== t.d))
            begin n_fail++; $display("FAIL mem_drive: wr=%b rd=%b a=%h d=%h required wr=%b a=%h d=%h", mem_wr, mem_rd, mem_addr, mem_wdata, t.w, t.a, t.d); end
          last_wait[w] = total_grants - rise_at[w];
          n_checks++;
          if (last_wait[w] > N - 1) begin n_fail++; $display("FAIL fairness: core %0d waited %0d required <= %0d", w, last_wait[w], N - 1); end
          m_ptr = w;
          if (t.w) m_mem[t.a[7:0]] = t.d;
          else     last_rdata = m_mem[t.a[7:0]];
          order.push_back(w);
          total_grants++;
          exp_core = w;
          in_txn = 1;
          age = 0;
        end
      end
      if (in_txn) age++;
      ack_prev = (ack != '0);
      busy_prev = busy;
      for (int c = 0; c < N; c++) begin
        if (!req[c] && !acked_mask[c] && scr[c].size() != 0) begin
          if (wait_cnt[c] > 0) wait_cnt[c]--;
          else begin
            t = scr[c][0];
            req[c] = 1'b1; we[c] = t.w;
            addr[c*16 +: 16] = t.a; wdata[c*16 +: 16] = t.d;
            rise_at[c] = total_grants;
          end
        end
      end
      req_edge = req;
      done = !in_txn && !busy && req == '0;
      for (int c = 0; c < N; c++) if (scr[c].size() != 0) done = 0;
    end
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL engine_timeout: scripts unfinished after %0d cycles", budget); end
  endtask

  task automatic check_order(input string name, input int exp_o [$]);
    n_checks++;
    if (order.size() != exp_o.size()) begin
      n_fail++; $display("FAIL %s_len: got %0d grants required %0d", name, order.size(), exp_o.size());
    end else begin
      for (int i = 0; i < exp_o.size(); i++) begin
        n_checks++;
        if (order[i] != exp_o[i]) begin n_fail++; $display("FAIL %s[%0d]: got core %0d required core %0d", name, i, order[i], exp_o[i]); end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ack, grant, busy, mem_wr, mem_rd} !== '0 || {rdata, mem_addr, mem_wdata} !== '0)
      begin n_fail++; $display("FAIL reset_outputs: ack=%b grant=%b busy=%b wr=%b rd=%b rdata=%h a=%h d=%h required all 0", ack, grant, busy, mem_wr, mem_rd, rdata, mem_addr, mem_wdata); end
    rst_n = 1'b1;
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[15:0] = 16'h00F0; wdata[15:0] = 16'h1234;
    @(negedge clk);
    n_checks++;
    if (mem_wr !== 1'b1 || grant !== 4'b0001) begin n_fail++; $display("FAIL reset_pre_access: wr=%b grant=%b required 1 0001", mem_wr, grant); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_wr, mem_rd, ack, grant, busy} !== '0)
      begin n_fail++; $display("FAIL reset_mid_access: wr=%b rd=%b ack=%b grant=%b busy=%b required all 0", mem_wr, mem_rd, ack, grant, busy); end
    @(negedge clk);
    req = '0;
    rst_n = 1'b1;
    m_ptr = N - 1; last_rdata = 16'h0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_single();
    req[1] = 1'b1; we[1] = 1'b1; addr[31:16] = 16'h0010; wdata[31:16] = 16'hBEEF;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0010 || mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 16'h0010 || mem_wdata !== 16'hBEEF || ack !== '0)
      begin n_fail++; $display("FAIL single_wr_access: grant=%b wr=%b rd=%b a=%h d=%h ack=%b required 0010 1 0 0010 beef 0000", grant, mem_wr, mem_rd, mem_addr, mem_wdata, ack); end
    @(negedge clk);
    n_checks++;
    if (ack !== 4'b0010 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL single_wr_ack: ack=%b wr=%b required 0010 0", ack, mem_wr); end
    req[1] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ack !== '0 || busy !== 1'b0 || grant !== '0) begin n_fail++; $display("FAIL single_wr_done: ack=%b busy=%b grant=%b required 0000 0 0000", ack, busy, grant); end
    req[1] = 1'b1; we[1] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || grant !== 4'b0010) begin n_fail++; $display("FAIL single_rd_access: rd=%b wr=%b grant=%b required 1 0 0010", mem_rd, mem_wr, grant); end
    @(negedge clk);
    n_checks++;
    if (ack !== 4'b0010 || rdata !== 16'hBEEF) begin n_fail++; $display("FAIL single_rd_ack: ack=%b rdata=%h required 0010 beef", ack, rdata); end
    req[1] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ack !== '0 || rdata !== 16'hBEEF) begin n_fail++; $display("FAIL single_rd_hold: ack=%b rdata=%h required 0000 beef", ack, rdata); end
    m_mem[8'h10] = 16'hBEEF; m_ptr = 1; last_rdata = 16'hBEEF;
  endtask

  task automatic test_contention();
    apply_reset();
    for (int round = 0; round < 2; round++) begin
      order.delete();
      for (int c = 0; c < N; c++) add_txn(c, (c % 2) == 0, 16'(16'h20 + c), 16'(16'hA000 + round * 16 + c), 0);
      run_engine(200);
      check_order(round == 0 ? "contention_a" : "contention_b", '{0, 1, 2, 3});
    end
  endtask

  task automatic test_wrap();
    order.delete();
    add_txn(0, 1'b0, 16'h0021, 16'h0, 0);
    add_txn(2, 1'b0, 16'h0022, 16'h0, 0);
    run_engine(100);
    check_order("wrap", '{0, 2});
  endtask

  task automatic test_starvation();
    order.delete();
    for (int i = 0; i < 6; i++) add_txn(0, 1'(i % 2), 16'(16'h30 + i), 16'(16'h5000 + i), 0);
    add_txn(3, 1'b0, 16'h0030, 16'h0, 3);
    run_engine(200);
    n_checks++;
    if (last_wait[3] > 1) begin n_fail++; $display("FAIL starvation: core3 waited %0d transactions required <= 1", last_wait[3]); end
  endtask

  task automatic test_random();
    order.delete();
    for (int c = 0; c < N; c++)
      for (int i = 0; i < 8; i++)
        add_txn(c, 1'($urandom_range(0, 1)), 16'(16'h20 + $urandom_range(0, 31)), 16'($urandom), $urandom_range(0, 3));
    run_engine(1500);
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    int n2;
    bit fin;
    apply_reset();
    order.delete();
    n2 = 0; fin = 0;
    req[2] = 1'b1; we[2] = 1'b0; addr[47:32] = 16'h0021; lock[2] = 1'b1;
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[15:0] = 16'h0022;
    for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
      @(negedge clk);
      if (ack != '0) begin
        for (int c = 0; c < N; c++) if (ack[c]) order.push_back(c);
        if (ack[2]) begin
          n2++;
          if (n2 == 3) begin req[2] = 1'b0; lock[2] = 1'b0; end
        end
        if (ack[0]) begin req[0] = 1'b0; fin = 1; end
      end
    end
    check_order("lock", '{2, 2, 2, 0});
  endtask
`endif

  initial begin
    n_checks = 0; n_fail = 0; total_grants = 0;
    req = '0; we = '0; addr = '0; wdata = '0;
`ifdef ARB_LOCK_EN
    lock = '0;
`endif
    for (int i = 0; i < 256; i++) begin ram[i] = 16'h0; m_mem[i] = 16'h0; end
    for (int c = 0; c < N; c++) begin rise_at[c] = 0; last_wait[c] = 0; end
    m_ptr = N - 1; last_rdata = 16'h0;
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_starvation();
    test_random();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
